// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder that sums WIDTH-bit operands DIGIT bits per clock through a ripple
// chunk, keeping the carry between chunks. Define SERIAL_CHUNK_ADDER_SUB_EN to add a subtract port.
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [KW-1:0]    k;
    logic             cout_reg;
    logic             ovf_reg;
    logic             accept;
    logic             last_chunk;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [DIGIT-1:0] chunk_sum;
    logic [DIGIT:0]   chain;

    // A start is honoured whenever no operation is in flight, including the DONE cycle.
    assign accept     = start && (state != RUN);
    assign last_chunk = (k == LAST_K);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Operands shift down each RUN cycle, so the active chunk always sits in the low bits.
    assign chain[0] = carry_reg;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign chunk_sum[i] = a_reg[i] ^ b_reg[i] ^ chain[i];
        assign chain[i+1]   = (a_reg[i] & b_reg[i]) | (chain[i] & (a_reg[i] ^ b_reg[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b_in;
            carry_reg <= c_in;
            k         <= '0;
        end else if (state == RUN) begin
            sum_reg[int'(k) * DIGIT +: DIGIT] <= chunk_sum;
            a_reg     <= a_reg >> DIGIT;
            b_reg     <= b_reg >> DIGIT;
            carry_reg <= chain[DIGIT];
            k         <= k + KW'(1);
            // Carry into the MSB is the ripple carry entering the top cell of the final chunk.
            if (last_chunk) begin
                cout_reg <= chain[DIGIT];
                ovf_reg  <= chain[DIGIT] ^ chain[DIGIT-1];
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule
